// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_pkg
//  Description : Shared state type, channel constants and the lowest-enabled
//                channel helper for the scan sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package scan_seq_pkg;

   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Lowest set bit of the mask; returns 0 for an empty mask.
   function automatic logic [SEL_W-1:0] first_set(input logic [N_CH-1:0] mask);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_next_chan_finder.sv
`default_nettype none
// ============================================================================
//  Module      : next_chan_finder
//  Description : Combinational wrapping priority search. Finds the next
//                enabled channel above cur (modulo N_CH) and flags when the
//                search wrapped, which marks the end of a pass.
//  Revision    : 1.0  initial release
// ============================================================================
module next_chan_finder #(
   parameter int N_CH  = 8,
   parameter int SEL_W = 3
) (
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] nxt,
   output logic             wrapped
);

   logic [SEL_W-1:0] w_idx;
   logic             w_found;

   // Scan cur+1, cur+2, ... cur+N_CH (the last being cur itself); the select
   // width equals log2(N_CH), so the addition wraps naturally.
   always_comb begin
      nxt     = cur;
      w_idx   = cur;
      w_found = 1'b0;
      for (int i = 1; i <= N_CH; i++) begin
         w_idx = cur + SEL_W'(i);
         if (!w_found && mask[w_idx]) begin
            nxt     = w_idx;
            w_found = 1'b1;
         end
      end
      wrapped = (nxt <= cur);
   end

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sequencer
//  Description : Steps a decoder select through the enabled channels of a
//                latched mask, holding each for max(dwell,1) cycles, in
//                single-pass or continuous mode with an end-of-pass pulse.
//                Define SCAN_SEQ_GAP_EN to insert a one-cycle break-before-make
//                gap (sel_en low, sel already on the next channel) between
//                consecutive channels.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_sequencer #(
   parameter int N_CH    = 8,
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [N_CH-1:0]    chan_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_en,
   output logic               busy,
   output logic               pass_done
);

   import scan_seq_pkg::*;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_CH-1:0]    r_mask;
   logic [DWELL_W-1:0] r_dwell;
   logic               r_cont;
   logic [DWELL_W-1:0] r_cnt;
   logic [SEL_W-1:0]   r_sel;

   logic [SEL_W-1:0]   w_sel_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic               w_load;
   logic [DWELL_W-1:0] w_dwell_eff;
   logic [SEL_W-1:0]   w_nxt;
   logic               w_wrapped;

   assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign sel         = r_sel;

   next_chan_finder #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_finder (
      .mask    (r_mask),
      .cur     (r_sel),
      .nxt     (w_nxt),
      .wrapped (w_wrapped)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state, channel advance and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      sel_en      = 1'b0;
      busy        = 1'b0;
      pass_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop && (chan_mask != '0)) begin
               w_state_nxt = DWELL;
               w_sel_nxt   = first_set(chan_mask);
               w_cnt_nxt   = w_dwell_eff;
               w_load      = 1'b1;
            end
         end
         DWELL: begin
            sel_en = 1'b1;
            busy   = 1'b1;
            if (stop) begin
               // Abort wins over an expiring count; no end-of-pass pulse.
               w_state_nxt = IDLE;
               w_sel_nxt   = '0;
            end else if (r_cnt == DWELL_W'(1)) begin
               pass_done = w_wrapped;
               if (w_wrapped && !r_cont) begin
                  w_state_nxt = IDLE;
                  w_sel_nxt   = '0;
               end else begin
`ifdef SCAN_SEQ_GAP_EN
                  w_state_nxt = GAP;
                  w_sel_nxt   = w_nxt;
`else
                  w_sel_nxt   = w_nxt;
                  w_cnt_nxt   = r_dwell;
`endif
               end
            end else begin
               w_cnt_nxt = r_cnt - DWELL_W'(1);
            end
         end
         GAP: begin
            busy = 1'b1;
            if (stop) begin
               w_state_nxt = IDLE;
               w_sel_nxt   = '0;
            end else begin
               w_state_nxt = DWELL;
               w_cnt_nxt   = r_dwell;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
         end
      endcase
   end

   // Datapath: select, dwell counter and the configuration latched at start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel   <= '0;
         r_cnt   <= '0;
         r_mask  <= '0;
         r_dwell <= '0;
         r_cont  <= 1'b0;
      end else begin
         r_sel <= w_sel_nxt;
         r_cnt <= w_cnt_nxt;
         if (w_load) begin
            r_mask  <= chan_mask;
            r_dwell <= w_dwell_eff;
            r_cont  <= cont;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Upstream driver for the 3-to-8 decoder. Steps a 3-bit select through the enabled channels of an 8-channel mask and holds each channel for a programmable dwell. It supplies the decoder's select and enable inputs, producing one-hot channel strobes for display, keypad or mux scanning. It supports single-pass and continuous modes, with start/stop control and an end-of-pass pulse.

Parameters:
- N_CH, 8, number of channels; must equal 2**SEL_W.
- SEL_W, 3, select width.
- DWELL_W, 8, width of the dwell count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled in IDLE only.
- stop  input  1  abort the scan; return to IDLE.
- cont  input  1  1 = continuous wrap, 0 = single pass; latched at start.
- chan_mask  input  N_CH  1 = channel enabled; latched at start.
- dwell  input  DWELL_W  cycles per channel; 0 is treated as 1; latched at start.
- sel  output  SEL_W  channel index, drives the decoder select.
- sel_en  output  1  drives the decoder enable.
- busy  output  1  high while not IDLE.
- pass_done  output  1  one-cycle pulse at the end of each full pass.

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - sel=0, sel_en=0, busy=0, pass_done=0.
  - Latched mask, dwell and mode are cleared.
- States: IDLE, DWELL.
- IDLE:
  - sel=0, sel_en=0.
  - On a start edge with start=1, stop=0 and chan_mask!=0: latch mask, dwell and cont, then go to DWELL.
  - sel becomes the lowest enabled index and sel_en=1 from the next cycle, so latency is 1 cycle.
  - start with chan_mask==0 is ignored: stay in IDLE with no pass_done.
- DWELL:
  - A down-counter loads max(dwell,1).
  - sel and sel_en=1 hold for exactly max(dwell,1) cycles.
  - When the count expires, advance to the next enabled index above sel, wrapping modulo N_CH. The next channel appears on the following cycle with no gap and no idle cycle for masked channels.
- End of pass: the count expires on the highest enabled index.
  - pass_done=1 in that cycle.
  - cont=1: wrap to the lowest enabled index.
  - cont=0: go to IDLE; sel_en=0 and busy=0 on the next cycle.
- Single enabled channel:
  - cont=1: the channel holds, with pass_done every max(dwell,1) cycles.
  - cont=0: one dwell, then IDLE.
- stop=1 in DWELL: go to IDLE on the next edge. sel_en drops then; no pass_done is issued, even if the count expires in the same cycle.
- start and stop both high: stop wins.
- start while busy: ignored.
- Input changes while busy: mask, dwell and cont changes are ignored until the next start.
- Reset mid-scan: immediate IDLE with outputs at their reset values.
- Invariant: sel_en=1 implies the latched mask bit at sel is 1.

Optional Feature:
- Macro: SCAN_SEQ_GAP_EN.
- Defined:
  - Adds a GAP state: one cycle with sel_en=0 between consecutive channels (break-before-make).
  - sel already shows the next index during GAP.
  - pass_done still fires on the final dwell cycle.
  - Continuous wrap also inserts a GAP.
  - stop during GAP goes to IDLE.
- Undefined: no GAP state; channel changes are back-to-back as described above.

Decomposition:
- Package scan_seq_pkg:
  - state enum (IDLE, DWELL, GAP).
  - N_CH and SEL_W constants.
  - Function first_set(mask) for the lowest enabled index.
- Sub-module next_chan_finder: combinational wrapping priority search.
  - Inputs: mask[N_CH-1:0], cur[SEL_W-1:0].
  - Outputs: nxt[SEL_W-1:0], wrapped (nxt <= cur, i.e. end of pass).

Test Plan:
- Basic pass:
  - Stimulus: mask=8'hFF, dwell=2, cont=0, start pulse.
  - Response: sel=0..7, each held 2 cycles with sel_en=1; pass_done on the 2nd cycle of sel=7; IDLE after 16 busy cycles.
- Sparse mask:
  - Stimulus: mask=8'b1010_0100, dwell=0, cont=1.
  - Response: sel sequence 2,5,7,2,5,7,… one cycle each; pass_done on every sel=7 cycle.
- Degenerate mask:
  - Stimulus: mask=0 with start.
  - Response: busy stays 0, no sel_en.
  - Stimulus: mask=8'h10, cont=0, dwell=3.
  - Response: sel=4 for 3 cycles, one pass_done, then IDLE.
- Control conflicts:
  - Stimulus: stop asserted mid-dwell at sel=3.
  - Response: sel_en=0 and busy=0 next cycle, no pass_done.
  - Stimulus: start and stop together in IDLE.
  - Response: remains IDLE.
  - Stimulus: mask changed while busy.
  - Response: sequence unaffected.
- Async reset:
  - Stimulus: rst asserted between clock edges mid-scan.
  - Response: all outputs 0 immediately, without a clock edge.
  - Stimulus: a new start after reset.
  - Response: scan begins at the lowest enabled index.
- SCAN_SEQ_GAP_EN defined:
  - Stimulus: mask=8'h03, dwell=1, cont=1.
  - Response: sel_en pattern 1,0,1,0…; sel 0,1(gap),1,0(gap),0…; decoder output never shows two channels in consecutive cycles.
